// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with optional skid buffer and synchronous flush.
//   Optional feature macro: PIPE_STAGE_SKID_EN (defined -> two-entry stage with registered ready_o,
//   undefined -> single-entry stage whose ready_o is combinational from ready_i).
//   Parameters: WIDTH (payload bits), CLEAR_BUBBLE (zero payload registers whenever they empty).
//   Ports:
//     clock, reset   - rising-edge clock, synchronous active-high reset
//     discard        - synchronous flush of all held entries
//     valid_i/ready_o/data_i - upstream handshake and payload
//     valid_o/ready_i/data_o - downstream handshake and registered payload
//     count_o        - registered number of held entries (0..2)
module pipe_stage #(
  parameter int WIDTH        = 64,
  parameter bit CLEAR_BUBBLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             discard,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [1:0]       count_d, count_q;
  logic             accept, drain;
  assign drain   = valid_q && ready_i;
  assign accept  = valid_i && ready_o;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid_d, skid_valid_q;
  logic [WIDTH-1:0] skid_data_d, skid_data_q;
  // ready_o depends only on registered state, breaking the ready_i->ready_o path
  assign ready_o = !reset && !skid_valid_q;
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      // ready_o is low here, so only the skid-to-main move can happen
      if (drain) begin
        valid_d      = 1'b1;
        data_d       = skid_data_q;
        skid_valid_d = 1'b0;
        skid_data_d  = CLEAR_BUBBLE ? '0 : skid_data_q;
      end
    end else if (!valid_q || drain) begin
      valid_d = accept;
      data_d  = accept ? data_i : (CLEAR_BUBBLE ? '0 : data_q);
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
    if (discard) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      data_d       = CLEAR_BUBBLE ? '0 : data_d;
      skid_data_d  = CLEAR_BUBBLE ? '0 : skid_data_d;
    end
    count_d = 2'(valid_d) + 2'(skid_valid_d);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // Without a skid entry the stage can only take new data if main frees up this cycle
  assign ready_o = !reset && (!valid_q || ready_i);
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!valid_q || drain) begin
      valid_d = accept;
      data_d  = accept ? data_i : (CLEAR_BUBBLE ? '0 : data_q);
    end
    if (discard) begin
      valid_d = 1'b0;
      data_d  = CLEAR_BUBBLE ? '0 : data_d;
    end
    count_d = 2'(valid_d);
  end
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= 2'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: randomized and directed checks of pipe_stage against a queue-based FIFO model.
module tb_pipe_stage;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       discard = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_i = 8'h00;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic [1:0] count_o;
  int errors = 0;
  int checks = 0;
  logic [7:0] mq[$];

  pipe_stage #(.WIDTH(8), .CLEAR_BUBBLE(1'b1)) dut (
    .clock(clock), .reset(reset), .discard(discard),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .count_o(count_o)
  );

  always #5 clock = ~clock;

  // Capacity rule: the skid build holds two entries, the plain build one entry that can be
  // replaced in the same cycle it is consumed.
  function automatic logic exp_ready();
`ifdef PIPE_STAGE_SKID_EN
    return !reset && (mq.size() < 2);
`else
    return !reset && (mq.size() == 0 || ready_i);
`endif
  endfunction

  function automatic logic [7:0] exp_data();
    return (mq.size() > 0) ? mq[0] : 8'h00;
  endfunction

  function automatic logic exp_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [1:0] exp_count();
    return 2'(mq.size());
  endfunction

  task automatic tick();
    logic acc, drn;
    acc = valid_i && exp_ready();
    drn = (mq.size() > 0) && ready_i;
    if (reset || discard) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(data_i);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_i = 1'b1; data_i = 8'h3C; ready_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    tick(); tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", data_o); end
    checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count_o); end
    reset = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b want=1", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b want=0", valid_o); end
  endtask

  task automatic test_single();
    valid_i = 1'b1; data_i = 8'h11; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", valid_o); end
    checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL single_data got=%h want=11", data_o); end
    checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL single_count got=%0d want=1", count_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_empty_valid got=%b want=0", valid_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL single_bubble_data got=%h want=00", data_o); end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1; data_i = 8'(i);
      tick();
      checks++; if (valid_o !== 1'b1 || data_o !== 8'(i) || count_o !== 2'd1)
        begin errors++; $display("FAIL stream_%0d got v=%b d=%h c=%0d want v=1 d=%h c=1", i, valid_o, data_o, count_o, 8'(i)); end
    end
    valid_i = 1'b0;
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_end_valid got=%b want=0", valid_o); end
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_skid();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 8'hA0;
    tick();
    data_i = 8'hA1;
    tick();
    valid_i = 1'b0;
    checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL skid_count got=%0d want=2", count_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL skid_ready got=%b want=0", ready_o); end
    tick();
    checks++; if (data_o !== 8'hA0 || valid_o !== 1'b1) begin errors++; $display("FAIL skid_hold got v=%b d=%h want v=1 d=a0", valid_o, data_o); end
    ready_i = 1'b1;
    #1;
    checks++; if (data_o !== 8'hA0) begin errors++; $display("FAIL skid_first got=%h want=a0", data_o); end
    tick();
    checks++; if (data_o !== 8'hA1 || count_o !== 2'd1) begin errors++; $display("FAIL skid_second got d=%h c=%0d want d=a1 c=1", data_o, count_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL skid_ready_back got=%b want=1", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL skid_drained got=%b want=0", valid_o); end
  endtask
`else
  task automatic test_comb_ready();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h5A;
    tick();
    valid_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL comb_ready_low got=%b want=0", ready_o); end
    ready_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL comb_ready_high got=%b want=1", ready_o); end
    valid_i = 1'b1; data_i = 8'h5B; ready_i = 1'b0;
    tick();
    checks++; if (count_o !== 2'd1 || data_o !== 8'h5A) begin errors++; $display("FAIL comb_full got c=%0d d=%h want c=1 d=5a", count_o, data_o); end
    ready_i = 1'b1; valid_i = 1'b0;
    tick(); tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL comb_drained got=%b want=0", valid_o); end
  endtask
`endif

  task automatic test_discard();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 8'hB0;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    data_i = 8'hB1;
    tick();
`endif
    checks++; if (count_o !== exp_count()) begin errors++; $display("FAIL discard_fill got=%0d want=%0d", count_o, exp_count()); end
    discard = 1'b1; data_i = 8'hFF;
    tick();
    discard = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || count_o !== 2'd0 || data_o !== 8'h00)
      begin errors++; $display("FAIL discard_flush got v=%b c=%0d d=%h want v=0 c=0 d=00", valid_o, count_o, data_o); end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid_o !== 1'b0 || data_o === 8'hFF) begin errors++; $display("FAIL discard_leak got v=%b d=%h want v=0 d=00", valid_o, data_o); end
    end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h55;
    tick();
    valid_i = 1'b0;
    checks++; if (data_o !== 8'h55) begin errors++; $display("FAIL rmid_held got=%h want=55", data_o); end
    reset = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready got=%b want=0", ready_o); end
    tick();
    reset = 1'b0;
    checks++; if (valid_o !== 1'b0 || data_o !== 8'h00 || count_o !== 2'd0)
      begin errors++; $display("FAIL rmid_clear got v=%b d=%h c=%0d want v=0 d=00 c=0", valid_o, data_o, count_o); end
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready_after got=%b want=1", ready_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = ($urandom_range(0, 3) != 0);
      data_i  = 8'($urandom);
      discard = ($urandom_range(0, 19) == 0);
      reset   = ($urandom_range(0, 49) == 0);
      #1;
      checks++; if (ready_o !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, ready_o, exp_ready()); end
      tick();
      checks++; if (valid_o !== exp_valid() || data_o !== exp_data() || count_o !== exp_count())
        begin errors++; $display("FAIL rand_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d", i, valid_o, data_o, count_o, exp_valid(), exp_data(), exp_count()); end
    end
    reset = 1'b0; discard = 1'b0; valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef PIPE_STAGE_SKID_EN
    test_skid();
`else
    test_comb_ready();
`endif
    test_discard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, 64, payload bit width carried by the stage (1..512).
REQ-002 Parameter CLEAR_BUBBLE, 1, when 1 payload register loads 0 whenever it becomes empty; when 0 payload retains last value.
REQ-003 Port clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port discard  input  1  synchronous flush of all held entries (branch mispredict / exception).
REQ-006 Port valid_i  input  1  upstream entry present.
REQ-007 Port ready_o  output  1  stage can accept an entry this cycle.
REQ-008 Port data_i  input  WIDTH  upstream payload.
REQ-009 Port valid_o  output  1  downstream entry present (registered).
REQ-010 Port ready_i  input  1  downstream accepts this cycle.
REQ-011 Port data_o  output  WIDTH  downstream payload (registered).
REQ-012 Port count_o  output  2  entries held (0..2), registered.

Function
REQ-013 Accept = valid_i && ready_o; drain = valid_o && ready_i; both evaluated in same cycle, no priority between them.
REQ-014 Storage: main register (valid_o/data_o) plus one skid register (skid_valid/skid_data), strict FIFO order.
REQ-015 Main empty or draining, skid empty, accept: data_i loads main next cycle (latency 1 cycle).
REQ-016 Main full, not draining, accept: data_i loads skid; main unchanged.
REQ-017 Drain with skid full: skid moves to main, skid empties; ready_o is 0 that cycle so no accept occurs.
REQ-018 Drain, skid empty, no accept: main becomes empty; data_o loads 0 if CLEAR_BUBBLE=1.
REQ-019 Main full, no drain: valid_o and data_o held stable (no change while valid_o && !ready_i).
REQ-020 count_o = valid_o + skid_valid, updated with the same edge as the registers.
REQ-021 discard: next cycle valid_o=0, skid_valid=0, count_o=0, data_o=0 if CLEAR_BUBBLE=1; same-cycle accept dropped; same-cycle drain still counts as delivered downstream.
REQ-022 discard and reset asserted together: reset behaviour applies (identical outcome).
REQ-023 ready_o is 0 in any cycle reset is 1.

Reset
REQ-024 On reset edge: valid_o=0, skid_valid=0, data_o=0, skid_data=0, count_o=0.
REQ-025 First cycle after reset deasserts: ready_o=1, valid_o=0.
REQ-026 Reset mid-transfer discards both entries; no partial entry emitted.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN: defined -> skid register present, ready_o = !reset && !skid_valid (registered-only, no ready_i->ready_o combinational path), full throughput with one-cycle downstream stall absorbed.
REQ-028 PIPE_STAGE_SKID_EN undefined -> no skid register, ready_o = !reset && (!valid_o || ready_i) (combinational from ready_i), count_o max 1, REQ-016/017 not applicable; all other requirements unchanged.

Verification (WIDTH=8, CLEAR_BUBBLE=1)
REQ-029 Reset then valid_i=1, data_i=0x11, ready_i=1 for 1 cycle -> next cycle valid_o=1, data_o=0x11, count_o=1; following cycle valid_o=0, data_o=0x00.
REQ-030 Stream 0x01..0x08 at valid_i=1, ready_i=1 -> data_o 0x01..0x08 on consecutive cycles, no bubbles, count_o=1 throughout.
REQ-031 SKID_EN: main holds 0xA0, ready_i=0, send 0xA1 -> count_o=2, ready_o=0, data_o=0xA0 held; ready_i=1 -> 0xA0 then 0xA1 delivered in order, ready_o=1 after skid empties.
REQ-032 count_o=2, discard=1 with valid_i=1, data_i=0xFF -> next cycle valid_o=0, count_o=0, data_o=0x00, 0xFF never appears on data_o.
REQ-033 Entry 0x55 held with ready_i=0, assert reset 1 cycle -> valid_o=0, data_o=0x00, ready_o=0 during reset, ready_o=1 next cycle.
REQ-034 SKID_EN undefined: valid_o=1, toggle ready_i 0->1 -> ready_o follows ready_i in the same cycle; count_o never exceeds 1.
